// File: rtl/chan_reader_if.sv
// Channel-side handshake between a one-entry bypass FIFO and its consumer endpoint.
// The channel drives head status and data. The consumer drives the dequeue strobe.
interface chan_reader_if #(
    parameter int width = 1
);
    logic             NOT_EMPTY;
    logic [width-1:0] DEQ_VALUE;
    logic             DEQ;

    modport master (
        output NOT_EMPTY,
        output DEQ_VALUE,
        input  DEQ
    );

    modport slave (
        input  NOT_EMPTY,
        input  DEQ_VALUE,
        output DEQ
    );
endinterface

// File: rtl/chan_reader.sv
// Consumer endpoint: takes one token per model cycle from a bypass FIFO channel and holds it.
// It also counts model cycles and WAIT stalls, and latches a sticky flag on early RESET.
module chan_reader #(
    parameter int width = 1,
    parameter int cntw  = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    chan_reader_if.slave     chan,
    input  logic             RESET,
    output logic [width-1:0] OUT_READ,
    output logic             OUT_READ_VALID,
    output logic             DONE,
    output logic             ERROR,
    output logic [cntw-1:0]  CYCLE_COUNT,
    output logic [cntw-1:0]  STALL_COUNT
);
    typedef enum logic {
        WAIT = 1'b0,
        HAVE = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [width-1:0]  data_reg, data_next;
    logic              error_reg, error_next;
    logic [cntw-1:0]   cycle_reg, cycle_next;
    logic [cntw-1:0]   stall_reg, stall_next;
    logic              deq;
    logic              done;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg <= WAIT;
        end else begin
            state_reg <= state_next;
        end
    end

    // A RESET that coincides with a dequeue ends the cycle with that token, so stay in WAIT.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            WAIT:    if (deq && !RESET) state_next = HAVE;
            HAVE:    if (RESET)         state_next = WAIT;
            default: state_next = WAIT;
        endcase
    end

    // DEQ is gated by RST_N so that the channel is never popped while reset is held.
    always_comb begin
        deq      = 1'b0;
        done     = 1'b0;
        OUT_READ = data_reg;
        case (state_reg)
            WAIT: begin
                deq  = chan.NOT_EMPTY & RST_N;
                done = deq;
                if (deq) OUT_READ = chan.DEQ_VALUE;
            end
            HAVE:    done = 1'b1;
            default: done = 1'b0;
        endcase
    end

    assign chan.DEQ       = deq;
    assign DONE           = done;
    assign OUT_READ_VALID = done;
    assign ERROR          = error_reg;
    assign CYCLE_COUNT    = cycle_reg;
    assign STALL_COUNT    = stall_reg;

    always_comb begin
        data_next  = deq ? chan.DEQ_VALUE : data_reg;
        error_next = error_reg | (RESET & ~done);
        cycle_next = (RESET && done) ? cycle_reg + cntw'(1) : cycle_reg;
        stall_next = stall_reg;
        if (state_reg == WAIT && !chan.NOT_EMPTY && stall_reg != {cntw{1'b1}})
            stall_next = stall_reg + cntw'(1);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            data_reg  <= '0;
            error_reg <= 1'b0;
            cycle_reg <= '0;
            stall_reg <= '0;
        end else begin
            data_reg  <= data_next;
            error_reg <= error_next;
            cycle_reg <= cycle_next;
            stall_reg <= stall_next;
        end
    end
endmodule

// File: tb/tb_chan_reader.sv
// Directed bench: dut_a (cntw=16) covers handshake, stall and error behaviour.
// dut_b (cntw=2) receives the same stimulus and covers counter wrap and saturation.
module tb_chan_reader;
    logic       CLK = 1'b0;
    logic       RST_N;
    logic       RESET;
    logic       ne;
    logic [3:0] dv;

    logic [3:0]  out_a, out_b;
    logic        valid_a, valid_b, done_a, done_b, err_a, err_b;
    logic [15:0] cyc_a, stall_a;
    logic [1:0]  cyc_b, stall_b;

    int total = 0;
    int bad   = 0;

    chan_reader_if #(.width(4)) ch_a ();
    chan_reader_if #(.width(4)) ch_b ();

    assign ch_a.NOT_EMPTY = ne;
    assign ch_a.DEQ_VALUE = dv;
    assign ch_b.NOT_EMPTY = ne;
    assign ch_b.DEQ_VALUE = dv;

    chan_reader #(.width(4), .cntw(16)) dut_a (
        .CLK(CLK), .RST_N(RST_N), .chan(ch_a), .RESET(RESET),
        .OUT_READ(out_a), .OUT_READ_VALID(valid_a), .DONE(done_a), .ERROR(err_a),
        .CYCLE_COUNT(cyc_a), .STALL_COUNT(stall_a)
    );

    chan_reader #(.width(4), .cntw(2)) dut_b (
        .CLK(CLK), .RST_N(RST_N), .chan(ch_b), .RESET(RESET),
        .OUT_READ(out_b), .OUT_READ_VALID(valid_b), .DONE(done_b), .ERROR(err_b),
        .CYCLE_COUNT(cyc_b), .STALL_COUNT(stall_b)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 2 time units after the next rising edge, where new inputs are applied.
    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        RST_N = 1'b0; RESET = 1'b0; ne = 1'b0; dv = 4'h0;
        #2;
        chk("rst_deq",   ch_a.DEQ, 0);
        chk("rst_out",   out_a, 0);
        chk("rst_valid", valid_a, 0);
        chk("rst_done",  done_a, 0);
        chk("rst_err",   err_a, 0);
        chk("rst_cyc",   cyc_a, 0);
        chk("rst_stall", stall_a, 0);

        // Test 1: release with a token present, bypass in the same cycle
        step(); RST_N = 1'b1; ne = 1'b1; dv = 4'h5; #1;
        chk("t1_deq", ch_a.DEQ, 1); chk("t1_done", done_a, 1); chk("t1_out", out_a, 4'h5);
        chk("t1_valid", valid_a, 1);
        $display("t1 bypass: deq=%0b done=%0b out=%0h", ch_a.DEQ, done_a, out_a);
        step(); ne = 1'b0; #1;
        chk("t1_have_deq", ch_a.DEQ, 0); chk("t1_have_done", done_a, 1); chk("t1_have_out", out_a, 4'h5);
        step(); RESET = 1'b1; #1;
        chk("t1_rst_done", done_a, 1);
        step(); RESET = 1'b0; #1;
        chk("t1_end_done", done_a, 0); chk("t1_end_valid", valid_a, 0);
        chk("t1_end_cyc", cyc_a, 1); chk("t1_end_out", out_a, 4'h5); chk("t1_end_stall", stall_a, 0);
        chk("t6_cyc_1", cyc_b, 1);
        $display("t1 end: done=%0b cycle=%0d", done_a, cyc_a);

        // Test 2: three stall cycles, then token 0xA
        step(); #1;
        chk("t2_stall1", stall_a, 1); chk("t2_done1", done_a, 0);
        step(); #1;
        chk("t2_stall2", stall_a, 2); chk("t2_done2", done_a, 0);
        step(); ne = 1'b1; dv = 4'hA; #1;
        chk("t2_stall3", stall_a, 3); chk("t2_arr_done", done_a, 1); chk("t2_arr_out", out_a, 4'hA);
        $display("t2 arrival: stall=%0d done=%0b out=%0h", stall_a, done_a, out_a);

        // Test 5: channel stays non-empty while HAVE holds 0xA
        for (int i = 0; i < 4; i++) begin
            step(); ne = 1'b1; dv = 4'h7; #1;
            chk("t5_hold_deq", ch_a.DEQ, 0); chk("t5_hold_out", out_a, 4'hA);
        end
        step(); RESET = 1'b1; #1;
        chk("t5_rst_deq", ch_a.DEQ, 0); chk("t5_rst_done", done_a, 1);
        step(); RESET = 1'b0; #1;
        chk("t5_next_deq", ch_a.DEQ, 1); chk("t5_next_out", out_a, 4'h7); chk("t5_next_cyc", cyc_a, 2);
        chk("t6_cyc_2", cyc_b, 2);
        step(); #1;
        chk("t5_once_deq", ch_a.DEQ, 0); chk("t5_once_out", out_a, 4'h7);
        $display("t5 single dequeue: deq=%0b out=%0h", ch_a.DEQ, out_a);

        // Test 3: RESET coinciding with a dequeue
        step(); RESET = 1'b1; ne = 1'b0; #1;
        step(); RESET = 1'b0; #1;
        chk("t3_wait_done", done_a, 0); chk("t3_wait_cyc", cyc_a, 3);
        chk("t6_cyc_3", cyc_b, 3);
        step(); ne = 1'b1; dv = 4'h3; RESET = 1'b1; #1;
        chk("t3_co_deq", ch_a.DEQ, 1); chk("t3_co_done", done_a, 1); chk("t3_co_stall", stall_a, 4);
        step(); ne = 1'b0; RESET = 1'b0; #1;
        chk("t3_done", done_a, 0); chk("t3_valid", valid_a, 0); chk("t3_data", out_a, 4'h3);
        chk("t3_cyc", cyc_a, 4); chk("t3_deq", ch_a.DEQ, 0);
        chk("t6_cyc_0", cyc_b, 0);
        $display("t3 coincident: done=%0b data=%0h cycle=%0d", done_a, out_a, cyc_a);

        // Test 4: RESET in WAIT with an empty channel
        step(); RESET = 1'b1; #1;
        chk("t4_pre_err", err_a, 0); chk("t4_pre_stall", stall_a, 5);
        step(); RESET = 1'b0; #1;
        chk("t4_err", err_a, 1); chk("t4_cyc", cyc_a, 4); chk("t4_stall", stall_a, 6);
        chk("t4_done", done_a, 0); chk("t6_stall_sat", stall_b, 3);
        $display("t4 violation: error=%0b cycle=%0d", err_a, cyc_a);
        step(); ne = 1'b1; dv = 4'h9; #1;
        chk("t4_ok_done", done_a, 1); chk("t4_ok_out", out_a, 4'h9);
        step(); ne = 1'b0; RESET = 1'b1; #1;
        step(); RESET = 1'b0; #1;
        chk("t4_sticky", err_a, 1); chk("t4_cyc5", cyc_a, 5);
        chk("t6_cyc_1b", cyc_b, 1);
        $display("t6 wrap: cycle_b=%0d", cyc_b);

        // Test 6: asynchronous reset while holding a token
        step(); ne = 1'b1; dv = 4'hC; #1;
        chk("t6_deq", ch_a.DEQ, 1);
        step(); #1;
        chk("t6_have_out", out_a, 4'hC); chk("t6_have_deq", ch_a.DEQ, 0);
        #1; RST_N = 1'b0; #1;
        chk("t6_ar_deq", ch_a.DEQ, 0); chk("t6_ar_out", out_a, 0); chk("t6_ar_valid", valid_a, 0);
        chk("t6_ar_done", done_a, 0); chk("t6_ar_err", err_a, 0); chk("t6_ar_cyc", cyc_a, 0);
        chk("t6_ar_stall", stall_a, 0); chk("t6_ar_cyc_b", cyc_b, 0); chk("t6_ar_deq_b", ch_b.DEQ, 0);
        $display("t6 async reset: deq=%0b out=%0h done=%0b", ch_a.DEQ, out_a, done_a);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/chan_reader.md
Name: chan_reader

Overview:
- Consumer-side endpoint for the one-entry bypass FIFO channel used between multi-cycle partitions.
- Each model cycle it dequeues exactly one token from the channel and holds it stable for downstream logic.
- It asserts DONE once the current model cycle's token is available, and retires the token on the model-cycle RESET pulse.
- It also counts model cycles and host-cycle stalls, and flags protocol violations.

Parameters:
- width, 1, payload bit count; all data buses are width bits (width >= 1)
- cntw, 16, width of CYCLE_COUNT and STALL_COUNT

Ports:
- CLK  input  1  host clock
- RST_N  input  1  asynchronous active-low reset
- NOT_EMPTY  input  1  channel holds a token (or one is being enqueued this cycle)
- DEQ_VALUE  input  width  channel head data
- DEQ  output  1  dequeue strobe to channel
- RESET  input  1  end-of-model-cycle pulse, one host cycle wide
- OUT_READ  output  width  token value for the current model cycle
- OUT_READ_VALID  output  1  OUT_READ holds the current model cycle's token
- DONE  output  1  this endpoint has finished the current model cycle
- ERROR  output  1  sticky protocol-violation flag
- CYCLE_COUNT  output  cntw  number of completed model cycles
- STALL_COUNT  output  cntw  host cycles spent in WAIT with NOT_EMPTY=0, saturating

Behaviour:
- Reset: RST_N low clears all state asynchronously.
  - state=WAIT, data=0, ERROR=0, CYCLE_COUNT=0, STALL_COUNT=0.
  - Consequently DEQ=0, OUT_READ=0, OUT_READ_VALID=0, DONE=0.
- State machine has two states: WAIT (no token yet this model cycle) and HAVE (token captured).
- In WAIT:
  - DEQ = NOT_EMPTY, combinational.
  - On DEQ, data <= DEQ_VALUE and state goes to HAVE, unless RESET is high in the same cycle (see below).
  - Bypass: while DEQ=1, OUT_READ = DEQ_VALUE, OUT_READ_VALID=1 and DONE=1 in the same cycle. This gives zero-cycle latency from NOT_EMPTY to DONE.
  - When NOT_EMPTY=0: OUT_READ = data (last token), OUT_READ_VALID=0, DONE=0, and STALL_COUNT increments, saturating at all-ones.
- In HAVE:
  - DEQ=0; at most one dequeue per model cycle.
  - OUT_READ = data, OUT_READ_VALID=1, DONE=1.
  - NOT_EMPTY is ignored; the next token waits in the channel.
- RESET with DONE=1 (HAVE, or WAIT with DEQ in the same cycle):
  - Model cycle ends, next state = WAIT, CYCLE_COUNT increments and wraps modulo 2^cntw.
  - If in WAIT with DEQ, data still captures DEQ_VALUE.
  - If RESET and DEQ coincide, the dequeued token is consumed by the ending cycle. The next model cycle requires a new token.
- RESET with DONE=0 (WAIT, NOT_EMPTY=0): protocol violation.
  - ERROR <= 1 and stays set until RST_N.
  - RESET is otherwise ignored: state stays WAIT and CYCLE_COUNT is unchanged. STALL_COUNT still increments.
- Outputs: DEQ, DONE, OUT_READ_VALID and OUT_READ are combinational from state, data and NOT_EMPTY. Counters and ERROR are registered.
- Asserting RST_N low mid-model-cycle discards any held token. The channel is not re-dequeued for it.
- DEQ never asserts while NOT_EMPTY=0.

Test Plan:
1. Reset release, then NOT_EMPTY=1 with DEQ_VALUE=0x5 on host cycle 2:
   - Same cycle: DEQ=1, DONE=1, OUT_READ=0x5.
   - Cycle 3: state HAVE, DEQ=0, OUT_READ=0x5.
   - RESET on cycle 4 -> cycle 5: DONE=0, CYCLE_COUNT=1.
2. NOT_EMPTY held 0 for 3 cycles in WAIT, then token 0xA arrives:
   - STALL_COUNT=3, DONE=0 during the stall.
   - DONE=1 on the arrival cycle, OUT_READ=0xA.
3. RESET and DEQ in the same cycle (value 0x3):
   - Next cycle state=WAIT, DONE=0, data=0x3, CYCLE_COUNT increments by 1.
4. RESET pulsed in WAIT with NOT_EMPTY=0:
   - ERROR=1 next cycle, CYCLE_COUNT unchanged.
   - ERROR stays 1 through later normal cycles until RST_N pulse.
5. NOT_EMPTY held 1 in HAVE for 4 cycles:
   - DEQ=0 throughout, OUT_READ unchanged.
   - After RESET, DEQ=1 exactly once on the next host cycle.
6. cntw=2, run 5 full model cycles -> CYCLE_COUNT sequence 1,2,3,0,1. Then assert RST_N low mid-HAVE -> all outputs 0 immediately, without waiting for a clock edge.
